// File: rtl/glb_strm_rd_initiator.sv
// Stream read initiator: issues strided read requests and buffers in-order responses in a credit-reserved FIFO.
// Optional GLB_STRM_RD_ERR_CHK_EN: flags responses that arrive with nothing in flight on err.
module glb_strm_rd_initiator #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_num_words,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_req_en,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_res_valid,
    input  logic [DATA_WIDTH-1:0] rd_res_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [CNT_WIDTH-1:0]   num_q, issued, popped;
    logic [CNT_WIDTH-1:0]   issued_next, popped_next;
    logic [CW-1:0]          reserved, in_flight, res_next;
    logic                   req_q;
    logic                   iss, pop, acc, head_load, from_mem, bypass, mem_wr;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          mem_cnt;

    // The request flop is masked by clk_en so a frozen cycle never presents a request.
    assign rd_req_en = req_q & clk_en;

    always_comb begin
        iss         = rd_req_en;
        pop         = clk_en & out_valid & out_ready;
        acc         = clk_en & rd_res_valid & (in_flight != '0);
        head_load   = ~out_valid | out_ready;
        from_mem    = head_load & (mem_cnt != '0);
        bypass      = head_load & (mem_cnt == '0) & acc;
        mem_wr      = acc & ~bypass;
        res_next    = reserved + CW'(iss) - CW'(pop);
        issued_next = issued + CNT_WIDTH'(iss);
        popped_next = popped + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stride_q    <= '0;
            num_q       <= '0;
            issued      <= '0;
            popped      <= '0;
            reserved    <= '0;
            in_flight   <= '0;
            req_q       <= 1'b0;
            rd_req_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (clk_en) begin
            reserved  <= res_next;
            in_flight <= in_flight + CW'(iss) - CW'(acc);
            case (state)
                IDLE: begin
                    req_q <= 1'b0;
                    if (start) begin
                        num_q       <= cfg_num_words;
                        stride_q    <= cfg_stride;
                        rd_req_addr <= cfg_start_addr;
                        issued      <= '0;
                        popped      <= '0;
                        if (cfg_num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            req_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    issued <= issued_next;
                    popped <= popped_next;
                    if (iss)
                        rd_req_addr <= rd_req_addr + stride_q;
                    req_q <= (issued_next < num_q) && (res_next < DEPTH_C);
                    if (issued_next == num_q)
                        state <= DRAIN;
                end
                DRAIN: begin
                    popped <= popped_next;
                    req_q  <= 1'b0;
                    if (popped_next == num_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered head in front of the storage array; an empty FIFO bypasses straight into the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
        end else if (clk_en) begin
            if (mem_wr)
                wr_ptr <= wr_ptr + PW'(1);
            if (from_mem) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PW'(1);
            end else if (bypass) begin
                out_data  <= rd_res_data;
                out_valid <= 1'b1;
            end else if (head_load) begin
                out_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(from_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && mem_wr)
            mem[wr_ptr] <= rd_res_data;
    end

`ifdef GLB_STRM_RD_ERR_CHK_EN
    logic discard;
    assign discard = clk_en & rd_res_valid & (in_flight == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (clk_en) begin
            if (discard)
                err <= 1'b1;
            else if (state == IDLE && start)
                err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_glb_strm_rd_initiator.sv
// Scoreboard bench for glb_strm_rd_initiator: modelled addresses, delayed responder, in-order data queue.
module tb_glb_strm_rd_initiator;

    localparam int AW    = 19;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset, clk_en, start, rd_res_valid, out_ready;
    logic [AW-1:0] cfg_start_addr, cfg_stride, rd_req_addr;
    logic [CW-1:0] cfg_num_words;
    logic          busy, done, rd_req_en, out_valid, err;
    logic [DW-1:0] rd_res_data, out_data;

    always #5 clk = ~clk;

    glb_strm_rd_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .cfg_start_addr(cfg_start_addr),
        .cfg_stride(cfg_stride),
        .cfg_num_words(cfg_num_words),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_req_en(rd_req_en),
        .rd_req_addr(rd_req_addr),
        .rd_res_valid(rd_res_valid),
        .rd_res_data(rd_res_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .err(err)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    resp_t       resp_q[$];
    logic [63:0] exp_q[$];
    int          cyc, en_cyc, req_cnt, pop_cnt, done_cnt;
    int          first_req_cyc, last_req_cyc, last_pop_cyc, done_cyc;
    bit          busy_seen, inj;
    logic [AW-1:0] exp_addr, exp_stride;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        resp_q.delete();
        exp_q.delete();
        req_cnt       = 0;
        pop_cnt       = 0;
        done_cnt      = 0;
        first_req_cyc = -1;
        last_req_cyc  = -1;
        last_pop_cyc  = -1;
        done_cyc      = -1;
        busy_seen     = 1'b0;
    endtask

    // One clock: observe at negedge, drive this cycle's response, return just after posedge.
    task automatic step();
        logic [63:0] d;
        resp_t       r;
        @(negedge clk);
        if (rd_req_en) begin
            check_eq("req_addr", 64'(rd_req_addr), 64'(exp_addr));
            exp_addr = exp_addr + exp_stride;
            if (first_req_cyc < 0) begin
                first_req_cyc = cyc;
                check_eq("busy_at_first_req", 64'(busy), 64'd1);
            end
            last_req_cyc = cyc;
            d = {16'hC0DE, 16'(req_cnt), 13'h0, rd_req_addr};
            req_cnt++;
            check_eq("credit_limit", 64'(req_cnt - pop_cnt <= DEPTH), 64'd1);
            r.due  = en_cyc + 3;
            r.data = d;
            resp_q.push_back(r);
            exp_q.push_back(d);
        end
        if (clk_en && out_valid && out_ready) begin
            check_eq("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check_eq("out_data", out_data, exp_q.pop_front());
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("busy_at_done", 64'(busy), 64'd0);
        end
        if (busy) busy_seen = 1'b1;
        rd_res_valid = 1'b0;
        rd_res_data  = '0;
        if (inj) begin
            rd_res_valid = 1'b1;
            rd_res_data  = 64'hDEAD;
        end else if (clk_en && resp_q.size() > 0 && resp_q[0].due <= en_cyc) begin
            r = resp_q.pop_front();
            rd_res_valid = 1'b1;
            rd_res_data  = r.data;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (clk_en) en_cyc++;
    endtask

    task automatic start_run(input logic [AW-1:0] a, input logic [AW-1:0] s,
                             input logic [CW-1:0] n, output int s_cyc);
        clear_model();
        cfg_start_addr = a;
        cfg_stride     = s;
        cfg_num_words  = n;
        exp_addr       = a;
        exp_stride     = s;
        start          = 1'b1;
        s_cyc          = cyc;
        step();
        start          = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        check_eq("done_within_budget", 64'(done_cnt != 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int      s_cyc;
        logic    exp_err;
        logic [AW-1:0] frozen;
        int      frozen_cnt;

`ifdef GLB_STRM_RD_ERR_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; out_ready = 1'b1;
        rd_res_valid = 1'b0; rd_res_data = '0; inj = 1'b0;
        cfg_start_addr = '0; cfg_stride = '0; cfg_num_words = '0;
        exp_addr = '0; exp_stride = '0;
        cyc = 0; en_cyc = 0;
        clear_model();
        step(); step();
        reset = 1'b0;
        step();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_req_en", 64'(rd_req_en), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_req_addr", 64'(rd_req_addr), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);

        // basic stream
        start_run(19'h100, 19'd8, 16'd4, s_cyc);
        wait_done(60);
        check_eq("basic_req_cnt", 64'(req_cnt), 64'd4);
        check_eq("basic_pop_cnt", 64'(pop_cnt), 64'd4);
        check_eq("basic_first_req", 64'(first_req_cyc), 64'(s_cyc + 1));
        check_eq("basic_back_to_back", 64'(last_req_cyc), 64'(s_cyc + 4));
        check_eq("basic_done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        check_eq("basic_sb_empty", 64'(exp_q.size()), 64'd0);
        step();
        check_eq("basic_done_pulse", 64'(done), 64'd0);
        check_eq("basic_err", 64'(err), 64'd0);

        // zero words
        start_run(19'h40, 19'd4, 16'd0, s_cyc);
        step();
        check_eq("zero_done_cyc", 64'(done_cyc), 64'(s_cyc + 1));
        step(); step();
        check_eq("zero_req_cnt", 64'(req_cnt), 64'd0);
        check_eq("zero_busy_seen", 64'(busy_seen), 64'd0);
        check_eq("zero_done_cnt", 64'(done_cnt), 64'd1);

        // address wrap
        start_run(19'h7FFF8, 19'd8, 16'd3, s_cyc);
        wait_done(60);
        check_eq("wrap_req_cnt", 64'(req_cnt), 64'd3);
        check_eq("wrap_next_addr", 64'(exp_addr), 64'h10);
        step();

        // back-pressure, plus an ignored start while busy
        out_ready = 1'b0;
        start_run(19'h1000, 19'd16, 16'd20, s_cyc);
        for (int i = 0; i < 20; i++) step();
        check_eq("bp_req_stall_cnt", 64'(req_cnt), 64'd8);
        check_eq("bp_req_en_low", 64'(rd_req_en), 64'd0);
        cfg_num_words = 16'd5; cfg_start_addr = '0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("bp_ignored_start_req", 64'(req_cnt), 64'd8);
        check_eq("bp_busy_held", 64'(busy), 64'd1);
        out_ready = 1'b1;
        wait_done(200);
        check_eq("bp_req_cnt", 64'(req_cnt), 64'd20);
        check_eq("bp_pop_cnt", 64'(pop_cnt), 64'd20);
        check_eq("bp_done_cnt", 64'(done_cnt), 64'd1);
        step();

        // clk_en freeze mid-RUN
        start_run(19'h200, 19'd4, 16'd10, s_cyc);
        step(); step();
        clk_en = 1'b0;
        frozen = rd_req_addr;
        frozen_cnt = req_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("cen_req_en_low", 64'(rd_req_en), 64'd0);
            check_eq("cen_addr_frozen", 64'(rd_req_addr), 64'(frozen));
        end
        check_eq("cen_req_cnt_frozen", 64'(req_cnt), 64'(frozen_cnt));
        clk_en = 1'b1;
        wait_done(100);
        check_eq("cen_req_cnt", 64'(req_cnt), 64'd10);
        check_eq("cen_pop_cnt", 64'(pop_cnt), 64'd10);
        step();

        // reset mid-DRAIN, then a stray response
        out_ready = 1'b0;
        start_run(19'h300, 19'd8, 16'd4, s_cyc);
        for (int i = 0; i < 12; i++) step();
        check_eq("drain_busy", 64'(busy), 64'd1);
        check_eq("drain_fifo_has_data", 64'(out_valid), 64'd1);
        clear_model();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        step();
        check_eq("late_resp_err", 64'(err), 64'(exp_err));
        check_eq("late_resp_fifo_empty", 64'(out_valid), 64'd0);
        check_eq("late_resp_idle", 64'(busy), 64'd0);
        step(); step();
        check_eq("late_resp_fifo_still_empty", 64'(out_valid), 64'd0);
        check_eq("late_resp_err_sticky", 64'(err), 64'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_strm_rd_initiator.md
# glb_strm_rd_initiator

Core-side stream read initiator for a global buffer tile. It generates strided read-request packets into the tile's stream router and collects the in-order read responses that return over the router chain after a variable latency. Responses are buffered in a credit-reserved FIFO and handed to a ready/valid consumer, so no response is ever dropped or back-pressured.

## Interface
- ADDR_WIDTH, 19, byte address width of requests
- DATA_WIDTH, 64, response data width
- DEPTH, 8, response FIFO depth and maximum reserved credits (power of 2, ≥2)
- CNT_WIDTH, 16, width of word count
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global clock enable; all state holds when low
- cfg_start_addr  in  ADDR_WIDTH  first request address
- cfg_stride  in  ADDR_WIDTH  address increment per word
- cfg_num_words  in  CNT_WIDTH  words to read
- start  in  1  one-cycle start pulse
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- rd_req_en  out  1  request valid (to router, sw2sr direction)
- rd_req_addr  out  ADDR_WIDTH  request address
- rd_res_valid  in  1  response valid (from router, sr2sw direction)
- rd_res_data  in  DATA_WIDTH  response data
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_WIDTH  FIFO head data
- out_ready  in  1  consumer accepts head
- err  out  1  sticky unexpected-response flag

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE: start with clk_en high latches config, clears counters, and moves to RUN. If cfg_num_words==0, moves to DONE instead. A start in any other state is ignored.
- RUN: issues one request per cycle while `reserved < DEPTH`.
  - Address for request k is `cfg_start_addr + k*cfg_stride`, computed as a running sum that wraps modulo 2^ADDR_WIDTH.
  - After request num_words-1 is issued, moves to DRAIN.
- DRAIN: waits until `popped == num_words`, then moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- reserved: +1 per request issued, −1 per FIFO pop (out_valid && out_ready); both in the same cycle leaves it unchanged. Range 0..DEPTH.
- in_flight: +1 per request, −1 per accepted response.
- Response handling:
  - rd_res_valid with in_flight>0 pushes to the FIFO. Overflow is impossible by reservation.
  - rd_res_valid with in_flight==0 is discarded and the FIFO is unchanged.
- Responses are assumed in request order; no reordering is performed.
- clk_en low: rd_req_en forced 0 in that cycle, no counter, FIFO, or FSM update, rd_res_valid ignored. Upstream router shares clk_en.
- Reset mid-operation: all state cleared, FSM to IDLE, FIFO emptied. Late responses then hit in_flight==0 and are discarded.

## Timing
- Reset values:
  - busy, done, rd_req_en, out_valid, err = 0
  - rd_req_addr, out_data = 0
- All outputs are registered.
- start accepted at cycle t: busy=1 at t+1, first rd_req_en=1 at t+1 with addr = cfg_start_addr.
- Steady state is one request per cycle when credits are available. Credits freed by a pop at cycle p allow a new request at p+1.
- Response accepted at cycle n: out_valid=1 with that data at n+1 if the FIFO was empty (one-cycle registered FIFO latency).
- Last pop at cycle p: done=1 and busy=0 at p+1.
- num_words==0: done at t+1, busy never asserted, no request issued.

## Configuration
- GLB_STRM_RD_ERR_CHK_EN defined:
  - A discarded response (in_flight==0) sets err at the next cycle.
  - err clears only on reset or on an accepted start.
- Not defined: err tied 0; discarded responses are silently dropped.

## Test plan
- Basic stream: start=0x100, stride=8, num_words=4, fixed 3-cycle response delay, out_ready=1.
  - Required: addresses 0x100, 0x108, 0x110, 0x118 on consecutive cycles from t+1; 4 outputs in order; done one cycle after the last pop.
- Back-pressure: num_words=20, DEPTH=8, out_ready=0.
  - Required: exactly 8 requests, then rd_req_en stays 0.
  - Raise out_ready: remaining 12 requests issue with at most one per pop; all 20 data words arrive in order.
- Wrap: ADDR_WIDTH=19, start=0x7FFF8, stride=8, num_words=3.
  - Required: addresses 0x7FFF8, 0x00000, 0x00008.
- Corner starts: num_words=0 gives done at t+1 with no requests; a start pulse while busy is ignored and leaves the count unchanged.
- clk_en and reset: drop clk_en for 5 cycles mid-RUN, which must freeze addresses and counts with no duplicates. Assert reset mid-DRAIN, then inject one response.
  - With GLB_STRM_RD_ERR_CHK_EN: err=1.
  - Without it: err=0.
  - In both cases the FIFO stays empty.
